// File: rtl/stage1_fetch.sv
// Instruction fetch stage: issues word-aligned requests to instruction memory,
// queues in-order responses and presents them to decode, with redirect/flush support.
package stage1_fetch_pkg;
    localparam int XLEN = 32;

    typedef logic [31:0] inst_t;

    typedef enum logic [1:0] {
        NO_EXCEPTION       = 2'd0,
        INSTR_MISALIGNED   = 2'd1,
        INSTR_ACCESS_FAULT = 2'd2
    } exc_type_e;
endpackage

module stage1_fetch
    import stage1_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h8000_0000,
    parameter int              FQ_DEPTH     = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    input  logic            imem_err_i,
    output inst_t           inst_o,
    output logic [XLEN-1:0] pc_o,
    output logic            inst_valid_o,
    output exc_type_e       exc_type_o
);

    localparam int PW = $clog2(FQ_DEPTH);
    localparam int CW = $clog2(FQ_DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR_C = PW'(FQ_DEPTH - 1);
    localparam logic [CW:0]   DEPTH_C    = (CW+1)'(FQ_DEPTH);
    localparam inst_t         NOP_C      = 32'h0000_0013;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic            mis_pend_q, mis_pend_d;
    logic            mis_halt_q, mis_halt_d;

    inst_t           fq_data_q [FQ_DEPTH];
    logic [XLEN-1:0] fq_pc_q   [FQ_DEPTH];
    exc_type_e       fq_exc_q  [FQ_DEPTH];

    logic            resp_s, take_s, empty_s, pop_s, fifo_pop_s;
    logic            push_resp_s, push_mis_s, push_s, gnt_s;
    logic [CW-1:0]   live_outst_s;
    logic [XLEN-1:0] resp_pc_s;
    inst_t           resp_data_s, push_data_s;
    exc_type_e       resp_exc_s, push_exc_s;
    logic [XLEN-1:0] push_pc_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR_C) ? '0 : p + PW'(1);
    endfunction

    // Handshake, response classification and queue push/pop decisions.
    always_comb begin
        resp_s       = imem_rvalid_i && (outst_q != '0);
        take_s       = resp_s && !flush_i && (discard_q == '0);
        empty_s      = (cnt_q == '0);
        imem_req_o   = rst_ni && !flush_i && !mis_halt_q &&
                       (({1'b0, outst_q} + {1'b0, cnt_q}) < DEPTH_C);
        imem_addr_o  = {fetch_pc_q[XLEN-1:2], 2'b00};
        gnt_s        = imem_req_o && imem_gnt_i;
        // Requests since the last redirect are contiguous, so the oldest live one sits this far back.
        live_outst_s = outst_q - discard_q;
        resp_pc_s    = fetch_pc_q - XLEN'({live_outst_s, 2'b00});
        resp_data_s  = imem_err_i ? NOP_C : imem_rdata_i;
        resp_exc_s   = imem_err_i ? INSTR_ACCESS_FAULT : NO_EXCEPTION;
        inst_valid_o = !empty_s || take_s;
        pop_s        = inst_valid_o && !stall_i && !flush_i;
        fifo_pop_s   = pop_s && !empty_s;
        push_resp_s  = take_s && !(empty_s && pop_s);
        push_mis_s   = mis_pend_q && (discard_q == '0) && !flush_i;
        push_s       = push_resp_s || push_mis_s;
        if (push_mis_s) begin
            push_data_s = NOP_C;
            push_pc_s   = fetch_pc_q;
            push_exc_s  = INSTR_MISALIGNED;
        end else begin
            push_data_s = resp_data_s;
            push_pc_s   = resp_pc_s;
            push_exc_s  = resp_exc_s;
        end
    end

    // Decode-side view: queue head, or the arriving response when the queue is empty.
    always_comb begin
        inst_o     = '0;
        pc_o       = '0;
        exc_type_o = NO_EXCEPTION;
        if (!empty_s) begin
            inst_o     = fq_data_q[rd_ptr_q];
            pc_o       = fq_pc_q[rd_ptr_q];
            exc_type_o = fq_exc_q[rd_ptr_q];
        end else if (take_s) begin
            inst_o     = resp_data_s;
            pc_o       = resp_pc_s;
            exc_type_o = resp_exc_s;
        end else begin
            inst_o     = '0;
        end
    end

    // Next-state for fetch PC, counters, queue pointers and misaligned-redirect tracking.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        outst_d    = outst_q;
        discard_d  = discard_q;
        cnt_d      = cnt_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        mis_pend_d = mis_pend_q;
        mis_halt_d = mis_halt_q;

        case ({gnt_s, resp_s})
            2'b10:   outst_d = outst_q + CW'(1);
            2'b01:   outst_d = outst_q - CW'(1);
            default: outst_d = outst_q;
        endcase

        if (flush_i) begin
            fetch_pc_d = redirect_pc_i;
            discard_d  = resp_s ? (outst_q - CW'(1)) : outst_q;
            cnt_d      = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            mis_pend_d = (redirect_pc_i[1:0] != 2'b00);
            mis_halt_d = (redirect_pc_i[1:0] != 2'b00);
        end else begin
            if (gnt_s) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            if (resp_s && (discard_q != '0)) begin
                discard_d = discard_q - CW'(1);
            end else begin
                discard_d = discard_q;
            end
            if (push_s) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (fifo_pop_s) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (push_s && !fifo_pop_s) begin
                cnt_d = cnt_q + CW'(1);
            end else if (!push_s && fifo_pop_s) begin
                cnt_d = cnt_q - CW'(1);
            end else begin
                cnt_d = cnt_q;
            end
            if (push_mis_s) begin
                mis_pend_d = 1'b0;
            end else begin
                mis_pend_d = mis_pend_q;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_pc_q <= RESET_VECTOR;
            outst_q    <= '0;
            discard_q  <= '0;
            cnt_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            mis_pend_q <= 1'b0;
            mis_halt_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            cnt_q      <= cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            mis_pend_q <= mis_pend_d;
            mis_halt_q <= mis_halt_d;
        end
    end

    // Fetch queue storage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < FQ_DEPTH; i++) begin
                fq_data_q[i] <= '0;
                fq_pc_q[i]   <= '0;
                fq_exc_q[i]  <= NO_EXCEPTION;
            end
        end else if (push_s) begin
            fq_data_q[wr_ptr_q] <= push_data_s;
            fq_pc_q[wr_ptr_q]   <= push_pc_s;
            fq_exc_q[wr_ptr_q]  <= push_exc_s;
        end
    end

endmodule
